// File: rtl/stage_mmu.sv
// Two-stage address translation unit: a small fully associative TLB keyed on
// {process, virtual page}, with a kernel bypass for process 0 and fault accounting.
module stage_mmu #(
   parameter int PAGE_BITS   = 6,
   parameter int TLB_ENTRIES = 8
) (
   input  logic                           clka,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [15:0]                    req_vaddr,
   input  logic [2:0]                     req_process,
   input  logic                           req_write,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [9:0]                     resp_paddr,
   output logic [1:0]                     resp_fault,
   input  logic                           cfg_we,
   input  logic [$clog2(TLB_ENTRIES)-1:0] cfg_index,
   input  logic [18:0]                    cfg_entry,
   output logic [7:0]                     fault_count
);

   localparam int VPN_W = 16 - PAGE_BITS;
   localparam int PPN_W = 10 - PAGE_BITS;

   typedef enum logic [1:0] {IDLE, MATCH, RESP} state_t;

   state_t             state;
   logic [15:0]        lat_vaddr;
   logic [2:0]         lat_process;
   logic               lat_write;
   logic [9:0]         res_paddr;
   logic [1:0]         res_fault;

   logic               tlb_valid    [TLB_ENTRIES];
   logic               tlb_writable [TLB_ENTRIES];
   logic [2:0]         tlb_process  [TLB_ENTRIES];
   logic [VPN_W-1:0]   tlb_vpn      [TLB_ENTRIES];
   logic [PPN_W-1:0]   tlb_ppn      [TLB_ENTRIES];

   logic               hit;
   logic               hit_writable;
   logic [PPN_W-1:0]   hit_ppn;
   logic [9:0]         next_paddr;
   logic [1:0]         next_fault;

   assign req_ready = (state == IDLE);

   // Only the valid bits need clearing on reset; the rest are don't-care until written.
   always_ff @(posedge clka) begin
      if (!rst) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            tlb_valid[i] <= 1'b0;
         end
      end else if (cfg_we) begin
         tlb_valid[cfg_index]    <= cfg_entry[18];
         tlb_writable[cfg_index] <= cfg_entry[17];
         tlb_process[cfg_index]  <= cfg_entry[16:14];
         tlb_vpn[cfg_index]      <= cfg_entry[4 +: VPN_W];
         tlb_ppn[cfg_index]      <= cfg_entry[0 +: PPN_W];
      end
   end

   // Scanning downwards lets the lowest matching index win.
   always_comb begin
      hit          = 1'b0;
      hit_writable = 1'b0;
      hit_ppn      = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (tlb_valid[i] && (tlb_process[i] == lat_process) &&
             (tlb_vpn[i] == lat_vaddr[15:PAGE_BITS])) begin
            hit          = 1'b1;
            hit_writable = tlb_writable[i];
            hit_ppn      = tlb_ppn[i];
         end
      end
   end

   always_comb begin
      next_paddr = '0;
      next_fault = 2'd0;
      if (lat_process == 3'd0) begin
         next_paddr = lat_vaddr[9:0];
         next_fault = (|lat_vaddr[15:10]) ? 2'd1 : 2'd0;
      end else if (hit) begin
         next_paddr = {hit_ppn, lat_vaddr[PAGE_BITS-1:0]};
         next_fault = (lat_write && !hit_writable) ? 2'd2 : 2'd0;
      end else begin
         next_fault = 2'd1;
      end
   end

   // RESP spends one cycle loading the output registers, giving the two-edge latency.
   always_ff @(posedge clka) begin
      if (!rst) begin
         state       <= IDLE;
         lat_vaddr   <= '0;
         lat_process <= '0;
         lat_write   <= 1'b0;
         res_paddr   <= '0;
         res_fault   <= '0;
         resp_valid  <= 1'b0;
         resp_paddr  <= '0;
         resp_fault  <= '0;
         fault_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_vaddr   <= req_vaddr;
                  lat_process <= req_process;
                  lat_write   <= req_write;
                  state       <= MATCH;
               end
            end
            MATCH: begin
               res_paddr <= next_paddr;
               res_fault <= next_fault;
               state     <= RESP;
            end
            RESP: begin
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_paddr <= res_paddr;
                  resp_fault <= res_fault;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
                  if ((resp_fault != 2'd0) && (fault_count != 8'hFF)) begin
                     fault_count <= fault_count + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_mmu.sv
// Scoreboard bench for stage_mmu: directed vectors push expected responses,
// a monitor pops and compares each accepted response.
module tb_stage_mmu;

   logic        clka;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_vaddr;
   logic [2:0]  req_process;
   logic        req_write;
   logic        resp_valid;
   logic        resp_ready;
   logic [9:0]  resp_paddr;
   logic [1:0]  resp_fault;
   logic        cfg_we;
   logic [2:0]  cfg_index;
   logic [18:0] cfg_entry;
   logic [7:0]  fault_count;

   typedef struct packed {
      logic [9:0] paddr;
      logic [1:0] fault;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   stage_mmu #(.PAGE_BITS(6), .TLB_ENTRIES(8)) dut (
      .clka        (clka),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_vaddr   (req_vaddr),
      .req_process (req_process),
      .req_write   (req_write),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_paddr  (resp_paddr),
      .resp_fault  (resp_fault),
      .cfg_we      (cfg_we),
      .cfg_index   (cfg_index),
      .cfg_entry   (cfg_entry),
      .fault_count (fault_count)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor samples just after the falling edge, after the driver has settled inputs.
   always begin
      exp_t e;
      @(negedge clka);
      #1;
      if (rst && resp_valid && resp_ready) begin
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_resp: got paddr 0x%0h fault %0d, expected none", resp_paddr, resp_fault);
         end else begin
            e = sb.pop_front();
            if (resp_paddr !== e.paddr || resp_fault !== e.fault) begin
               tests_failed++;
               $display("[TB] FAIL resp: got paddr 0x%0h fault %0d, expected paddr 0x%0h fault %0d",
                        resp_paddr, resp_fault, e.paddr, e.fault);
            end
         end
      end
   end

   task automatic cfgWrite(input logic [2:0] idx, input logic [18:0] entry);
      @(negedge clka);
      cfg_we    = 1'b1;
      cfg_index = idx;
      cfg_entry = entry;
      @(negedge clka);
      cfg_we    = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clka);
         n++;
      end
      if (!req_ready) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL idle_timeout: got req_ready 0, expected 1 within 50 cycles");
      end
   endtask

   // Issues one request at a falling edge and checks the two-edge response latency.
   task automatic applyStimulus(input logic [15:0] vaddr, input logic [2:0] proc, input logic wr,
                                input logic [9:0] exp_paddr, input logic [1:0] exp_fault);
      @(negedge clka);
      checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid   = 1'b1;
      req_vaddr   = vaddr;
      req_process = proc;
      req_write   = wr;
      sb.push_back(exp_t'{paddr: exp_paddr, fault: exp_fault});
      @(negedge clka);
      req_valid = 1'b0;
      @(negedge clka);
      checkOutput("latency_n1", {31'd0, resp_valid}, 32'd0);
      @(negedge clka);
      checkOutput("latency_n2", {31'd0, resp_valid}, 32'd1);
   endtask

   task automatic runVector(input logic [15:0] vaddr, input logic [2:0] proc, input logic wr,
                            input logic [9:0] exp_paddr, input logic [1:0] exp_fault);
      applyStimulus(vaddr, proc, wr, exp_paddr, exp_fault);
      waitIdle();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 500us");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_vaddr   = '0;
      req_process = '0;
      req_write   = 1'b0;
      resp_ready  = 1'b1;
      cfg_we      = 1'b0;
      cfg_index   = '0;
      cfg_entry   = '0;
      repeat (2) @(posedge clka);
      @(negedge clka);
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_resp_paddr", {22'd0, resp_paddr}, 32'd0);
      checkOutput("rst_resp_fault", {30'd0, resp_fault}, 32'd0);
      checkOutput("rst_fault_count", {24'd0, fault_count}, 32'd0);
      rst = 1'b1;

      // Hit, then miss for a different process.
      cfgWrite(3'd0, {1'b1, 1'b1, 3'd3, 10'd2, 4'd5});
      runVector(16'h0085, 3'd3, 1'b0, 10'h145, 2'd0);
      runVector(16'h0085, 3'd4, 1'b0, 10'h000, 2'd1);
      checkOutput("fault_count_1", {24'd0, fault_count}, 32'd1);

      // Write-protect, load through the same entry, then lowest-index priority.
      cfgWrite(3'd1, {1'b1, 1'b0, 3'd3, 10'd7, 4'd2});
      runVector(16'h01C3, 3'd3, 1'b1, 10'h083, 2'd2);
      checkOutput("fault_count_2", {24'd0, fault_count}, 32'd2);
      runVector(16'h01C3, 3'd3, 1'b0, 10'h083, 2'd0);
      cfgWrite(3'd2, {1'b1, 1'b1, 3'd3, 10'd2, 4'd9});
      runVector(16'h0085, 3'd3, 1'b0, 10'h145, 2'd0);

      // Kernel bypass edges.
      runVector(16'h03FF, 3'd0, 1'b0, 10'h3FF, 2'd0);
      runVector(16'h03FF, 3'd0, 1'b1, 10'h3FF, 2'd0);
      runVector(16'h0400, 3'd0, 1'b0, 10'h000, 2'd1);
      checkOutput("fault_count_3", {24'd0, fault_count}, 32'd3);

      // Backpressure with a competing request that must be ignored.
      resp_ready = 1'b0;
      applyStimulus(16'h0085, 3'd3, 1'b0, 10'h145, 2'd0);
      req_valid   = 1'b1;
      req_vaddr   = 16'h01C3;
      req_process = 3'd3;
      req_write   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clka);
         checkOutput("stall_valid", {31'd0, resp_valid}, 32'd1);
         checkOutput("stall_paddr", {22'd0, resp_paddr}, 32'h145);
         checkOutput("stall_fault", {30'd0, resp_fault}, 32'd0);
         checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      waitIdle();
      @(negedge clka);
      checkOutput("stall_no_extra", {31'd0, resp_valid}, 32'd0);

      // Invalidate entry 0 on the MATCH cycle: the old contents still hit.
      @(negedge clka);
      req_valid   = 1'b1;
      req_vaddr   = 16'h0085;
      req_process = 3'd3;
      req_write   = 1'b0;
      sb.push_back(exp_t'{paddr: 10'h145, fault: 2'd0});
      @(negedge clka);
      req_valid = 1'b0;
      cfg_we    = 1'b1;
      cfg_index = 3'd0;
      cfg_entry = '0;
      @(negedge clka);
      cfg_we = 1'b0;
      waitIdle();
      runVector(16'h0085, 3'd3, 1'b0, 10'h245, 2'd0);

      // Reset while in MATCH drops the request and clears the table.
      @(negedge clka);
      req_valid   = 1'b1;
      req_vaddr   = 16'h01C3;
      req_process = 3'd3;
      req_write   = 1'b0;
      @(negedge clka);
      req_valid = 1'b0;
      rst       = 1'b0;
      @(negedge clka);
      rst = 1'b1;
      checkOutput("mid_rst_fault_count", {24'd0, fault_count}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         checkOutput("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
         @(negedge clka);
      end
      checkOutput("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      runVector(16'h0085, 3'd3, 1'b0, 10'h000, 2'd1);
      checkOutput("post_rst_fault_count", {24'd0, fault_count}, 32'd1);

      // Counter saturation.
      for (int i = 0; i < 300; i++) begin
         runVector(16'h0085, 3'd4, 1'b0, 10'h000, 2'd1);
         if (i == 252) checkOutput("fault_count_254", {24'd0, fault_count}, 32'd254);
      end
      checkOutput("fault_count_sat", {24'd0, fault_count}, 32'd255);

      repeat (3) @(negedge clka);
      checkOutput("scoreboard_drain", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/stage_mmu.md
STAGE_MMU -- requirements
Module: stage_mmu

Interface
REQ-001 SHALL have parameter PAGE_BITS, default 6, words per page = 2**PAGE_BITS.
REQ-002 SHALL have parameter TLB_ENTRIES, default 8, number of translation entries (power of two).
REQ-003 SHALL have port clka  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  translation request present.
REQ-006 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port req_vaddr  input  16  virtual word address from fetch/decode stage.
REQ-008 SHALL have port req_process  input  3  process index of requester.
REQ-009 SHALL have port req_write  input  1  1 = store (port A), 0 = load/fetch (port B).
REQ-010 SHALL have port resp_valid  output  1  translation result present.
REQ-011 SHALL have port resp_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port resp_paddr  output  10  physical RAM address.
REQ-013 SHALL have port resp_fault  output  2  0 ok, 1 miss/out-of-range, 2 write-protect.
REQ-014 SHALL have port cfg_we  input  1  write one TLB entry.
REQ-015 SHALL have port cfg_index  input  log2(TLB_ENTRIES)  entry written.
REQ-016 SHALL have port cfg_entry  input  19  {valid, writable, process[2:0], vpn[9:0], ppn[3:0]}.
REQ-017 SHALL have port fault_count  output  8  saturating count of faulted responses.

Function
REQ-018 SHALL implement FSM IDLE -> MATCH -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-019 SHALL, in IDLE with req_valid, latch vaddr/process/write and enter MATCH next cycle.
REQ-020 SHALL, in MATCH, compare latched process and vaddr[15:PAGE_BITS] against every valid entry in parallel and register result; enter RESP.
REQ-021 SHALL assert resp_valid in RESP, holding resp_paddr/resp_fault stable until resp_ready; return to IDLE on the cycle resp_ready=1.
REQ-022 SHALL give latency of exactly 2 cycles: request accepted at edge N, resp_valid high after edge N+2.
REQ-023 SHALL, on hit, output resp_paddr = {ppn, vaddr[PAGE_BITS-1:0]} (ppn width = 10-PAGE_BITS).
REQ-024 SHALL, on multiple hits, use lowest-index entry.
REQ-025 SHALL, for process 0, bypass TLB: paddr = vaddr[9:0], fault 1 if vaddr[15:10] != 0, never write-protect.
REQ-026 SHALL report fault 1 on no hit (paddr = 0); fault 2 on hit with req_write=1 and writable=0 (paddr still driven).
REQ-027 SHALL increment fault_count by 1 when a response with fault != 0 is accepted; saturate at 255.
REQ-028 SHALL apply cfg_we at any state; a MATCH in the same cycle as cfg_we uses pre-write entry contents.
REQ-029 SHALL ignore req_valid outside IDLE (no queuing, no loss of held response).

Reset
REQ-030 SHALL, when rst=0 at a posedge, set FSM IDLE, all entries valid=0, resp_valid=0, resp_paddr=0, resp_fault=0, fault_count=0, req_ready=1 on following cycle.
REQ-031 SHALL discard any in-flight request or pending response on reset; no response emitted afterwards for it.

Verification
REQ-032 SHALL test hit: entry0={1,1,3,vpn 2,ppn 5}, req vaddr 0x0085 proc 3 load -> paddr 0x145, fault 0, resp_valid at N+2.
REQ-033 SHALL test miss and counter: req vaddr 0x0085 proc 4 -> fault 1, paddr 0, fault_count 1; 300 misses -> fault_count 255.
REQ-034 SHALL test write-protect: entry1={1,0,3,vpn 7,ppn 2}, store vaddr 0x01C3 proc 3 -> fault 2, paddr 0x083.
REQ-035 SHALL test kernel bypass: proc 0 vaddr 0x03FF -> paddr 0x3FF fault 0; vaddr 0x0400 -> fault 1.
REQ-036 SHALL test backpressure/collision: resp_ready low 5 cycles -> outputs stable, req_ready 0; cfg_we on MATCH cycle invalidating hit entry -> still hit.
REQ-037 SHALL test reset in MATCH: rst=0 one cycle -> resp_valid never asserts, entries invalid, next request misses.
